systolic_feeder_2x2: RTL and testbench
======================================

Name: systolic_feeder_2x2

Overview:
Upstream control and feed stage for the 2x2 systolic matrix-multiply array. It accepts operand matrices A and B in one handshake beat and clears the array. It then drives the four 16-bit edge inputs with the diagonally skewed operand schedule. After the pipeline drains, it captures the four 32-bit PE accumulators into a result register and presents them on a valid/ready output.

Parameters:
DATA_W, 16, operand element width; matches array edge inputs.
ACC_W, 32, accumulator width; matches array PE outputs.
DRAIN_CYCLES, 2, zero-feed cycles after the last operand before accumulators are sampled.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  synchronous, active-high.
load_valid  in  1  A/B operands valid.
load_ready  out  1  block idle; a load is accepted when load_valid && load_ready.
a_mat  in  4*DATA_W  A packed: [15:0]=A00, [31:16]=A01, [47:32]=A10, [63:48]=A11.
b_mat  in  4*DATA_W  B packed in the same order.
pe_clear  out  1  drives array reset; clears PE accumulators and pipeline registers.
feed_00_W  out  DATA_W  to array in_00_W (row 0 of A).
feed_10_W  out  DATA_W  to array in_10_W (row 1 of A).
feed_00_N  out  DATA_W  to array in_00_N (column 0 of B).
feed_01_N  out  DATA_W  to array in_01_N (column 1 of B).
acc_00, acc_01, acc_10, acc_11  in  ACC_W each  array PE outputs out_00..out_11.
res_valid  out  1  result register holds C.
res_ready  in  1  consumer accepts result.
res_c  out  4*ACC_W  C packed: [31:0]=C00, [63:32]=C01, [95:64]=C10, [127:96]=C11.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=IDLE, cnt=0, operand and result registers=0, res_valid=0, busy=0, all feed_* outputs=0.
- pe_clear is combinational: reset OR (state==CLEAR). The array is therefore cleared whenever this block is reset.
- load_ready=1 only in IDLE. It is combinational from state.
- IDLE: on a load handshake, latch a_mat/b_mat and go to CLEAR. A load_valid arriving in any other state is ignored.
- CLEAR: lasts 1 cycle. pe_clear=1 and feeds=0. Next state is FEED with cnt=0.
- FEED: lasts 3 cycles, cnt=0,1,2. Feed outputs are registered-state decodes, valid in the same cycle as cnt:
  - cnt0: 00_W=A00, 00_N=B00, 10_W=0, 01_N=0.
  - cnt1: 00_W=A01, 00_N=B10, 10_W=A10, 01_N=B01.
  - cnt2: 00_W=0, 00_N=0, 10_W=A11, 01_N=B11.
  - After cnt2, go to DRAIN with cnt=0.
- DRAIN: lasts DRAIN_CYCLES cycles with all feeds=0. On the last DRAIN cycle, register acc_00..acc_11 into res_c, set res_valid=1 and go to HOLD.
- HOLD: res_valid=1 and res_c stays stable. On res_valid && res_ready, clear res_valid in the next cycle and go to IDLE. res_c retains its value until the next capture.
- Latency: from load accept to res_valid=1 is 1 + 3 + DRAIN_CYCLES + 1 cycles; 7 cycles at the default.
- Throughput: one matrix product per 1 + 1 + 3 + DRAIN_CYCLES + 1 cycles when res_ready is tied high. No overlap between jobs.
- Arithmetic: the block does no arithmetic. Operands pass through unchanged and signedness is the array's concern.
- All feed_* outputs are 0 in IDLE, CLEAR, DRAIN and HOLD. No X values are ever driven.
- Reset asserted in any state, including mid-FEED: return to IDLE next cycle, discard the job, drop res_valid, and hold pe_clear=1 for the whole reset.
- res_ready asserted outside HOLD has no effect.

Decomposition:
- Shared package: FSM state enum (IDLE, CLEAR, FEED, DRAIN, HOLD), FEED_LEN=3, and the element pack/unpack index constants for 2x2 operands and results. The package is reused by the array top and the bench.
- One natural sub-module, systolic_skew_mux_2x2: a purely combinational decode of (state, cnt, latched A/B) to the four feed outputs. The FSM, counter, capture and handshake logic stay in the top.

Test Plan:
1. A=[[1,2],[3,4]], B=[[5,6],[7,8]], feeder wired to the 2x2 array, res_ready=1 -> res_valid exactly 7 cycles after the load handshake, with res_c C00=19, C01=22, C10=43, C11=50.
2. Same load, feeds monitored -> cnt0 (1,5,0,0), cnt1 (2,7,3,6), cnt2 (0,0,4,8), order (00_W, 00_N, 10_W, 01_N); zeros in every other cycle; pe_clear high exactly 1 cycle before cnt0.
3. res_ready held low for 5 cycles after res_valid -> res_c stable, load_ready=0, and a new load_valid is ignored; raise res_ready -> one transfer, load_ready=1 next cycle.
4. Reset pulsed during FEED cnt1 -> pe_clear=1 during reset, state IDLE next cycle, res_valid never rises; a following job with A=I, B=[[9,8],[7,6]] returns C=[[9,8],[7,6]].
5. Back-to-back jobs with load_valid held high and res_ready=1: A=[[1,2],[3,4]], B=[[5,6],[7,8]] then A=[[2,0],[0,2]], B=[[1,1],[1,1]] -> results 19/22/43/50 then 2/2/2/2, with no stale accumulation across jobs.
6. A and B all 16'hFFFF -> each result element equals the array's product-sum for those operands, i.e. the bench model's value; the feeder passes operands bit-exact.

Source files
------------

// File: rtl/systolic_feeder_2x2_pkg.sv
// Shared definitions for the 2x2 systolic feeder, array top and bench.
// Holds the FSM state enum, the feed schedule length, counter width and the
// element slot indices used to pack/unpack 2x2 operand and result matrices.
package systolic_feeder_2x2_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StFeed,
      StDrain,
      StHold
   } state_e;

   localparam int unsigned FEED_LEN = 3;
   localparam int unsigned CNT_W    = 4;

   // Element slot within a packed 2x2 matrix: slot * width selects the element.
   localparam int unsigned IDX_00 = 0;
   localparam int unsigned IDX_01 = 1;
   localparam int unsigned IDX_10 = 2;
   localparam int unsigned IDX_11 = 3;

endpackage

// File: rtl/systolic_feeder_2x2_if.sv
// Load / result handshake bundle for systolic_feeder_2x2.
//   load_valid/load_ready/a_mat/b_mat : operand beat into the feeder
//   res_valid/res_ready/res_c         : packed C result out of the feeder
// slave is the feeder's view, master is the producer/consumer's view.
interface systolic_feeder_2x2_if #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ACC_W  = 32
);
   logic                  load_valid;
   logic                  load_ready;
   logic [4*DATA_W-1:0]   a_mat;
   logic [4*DATA_W-1:0]   b_mat;
   logic                  res_valid;
   logic                  res_ready;
   logic [4*ACC_W-1:0]    res_c;

   modport master (
      output load_valid, a_mat, b_mat, res_ready,
      input  load_ready, res_valid, res_c
   );

   modport slave (
      input  load_valid, a_mat, b_mat, res_ready,
      output load_ready, res_valid, res_c
   );
endinterface

// File: rtl/systolic_skew_mux_2x2.sv
// Combinational skew decode for the 2x2 array edge inputs.
//   state, cnt    : feeder FSM state and step counter
//   a_q, b_q      : latched packed operands
//   feed_*        : array edge inputs; zero outside the three FEED steps
// Row 1 / column 1 lag row 0 / column 0 by one step to form the diagonal wave.
module systolic_skew_mux_2x2
   import systolic_feeder_2x2_pkg::*;
#(
   parameter int unsigned DATA_W = 16
) (
   input  state_e              state,
   input  logic [CNT_W-1:0]    cnt,
   input  logic [4*DATA_W-1:0] a_q,
   input  logic [4*DATA_W-1:0] b_q,
   output logic [DATA_W-1:0]   feed_00_W,
   output logic [DATA_W-1:0]   feed_10_W,
   output logic [DATA_W-1:0]   feed_00_N,
   output logic [DATA_W-1:0]   feed_01_N
);

   always_comb begin
      feed_00_W = '0;
      feed_10_W = '0;
      feed_00_N = '0;
      feed_01_N = '0;
      if (state == StFeed) begin
         case (cnt)
            CNT_W'(0): begin
               feed_00_W = a_q[IDX_00*DATA_W +: DATA_W];
               feed_00_N = b_q[IDX_00*DATA_W +: DATA_W];
            end
            CNT_W'(1): begin
               feed_00_W = a_q[IDX_01*DATA_W +: DATA_W];
               feed_00_N = b_q[IDX_10*DATA_W +: DATA_W];
               feed_10_W = a_q[IDX_10*DATA_W +: DATA_W];
               feed_01_N = b_q[IDX_01*DATA_W +: DATA_W];
            end
            CNT_W'(2): begin
               feed_10_W = a_q[IDX_11*DATA_W +: DATA_W];
               feed_01_N = b_q[IDX_11*DATA_W +: DATA_W];
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/systolic_feeder_2x2.sv
// Control and feed stage for the 2x2 systolic matrix-multiply array.
//   clk, reset      : clock, synchronous active-high reset
//   bus (slave)     : operand load handshake and C result handshake
//   pe_clear        : array clear (reset or CLEAR state)
//   feed_*          : skewed operand edge inputs to the array
//   acc_00..acc_11  : PE accumulators, captured on the last DRAIN cycle
//   busy            : high whenever a job is in flight or awaiting pickup
module systolic_feeder_2x2
   import systolic_feeder_2x2_pkg::*;
#(
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned ACC_W        = 32,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   systolic_feeder_2x2_if.slave bus,
   output logic                 pe_clear,
   output logic [DATA_W-1:0]    feed_00_W,
   output logic [DATA_W-1:0]    feed_10_W,
   output logic [DATA_W-1:0]    feed_00_N,
   output logic [DATA_W-1:0]    feed_01_N,
   input  logic [ACC_W-1:0]     acc_00,
   input  logic [ACC_W-1:0]     acc_01,
   input  logic [ACC_W-1:0]     acc_10,
   input  logic [ACC_W-1:0]     acc_11,
   output logic                 busy
);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [4*DATA_W-1:0]   a_q, a_d;
   logic [4*DATA_W-1:0]   b_q, b_d;
   logic [4*ACC_W-1:0]    res_q, res_d;
   logic                  res_valid_q, res_valid_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      res_valid_d = res_valid_q;
      case (state_q)
         StIdle: begin
            if (bus.load_valid) begin
               a_d     = bus.a_mat;
               b_d     = bus.b_mat;
               state_d = StClear;
            end
         end
         StClear: begin
            cnt_d   = '0;
            state_d = StFeed;
         end
         StFeed: begin
            if (cnt_q == CNT_W'(FEED_LEN - 1)) begin
               cnt_d   = '0;
               state_d = StDrain;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StDrain: begin
            if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) begin
               res_d       = {acc_11, acc_10, acc_01, acc_00};
               res_valid_d = 1'b1;
               cnt_d       = '0;
               state_d     = StHold;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StHold: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
      end
   end

   // Clear the array for the whole of reset as well as the CLEAR step.
   assign pe_clear      = reset | (state_q == StClear);
   assign bus.load_ready = (state_q == StIdle);
   assign bus.res_valid  = res_valid_q;
   assign bus.res_c      = res_q;
   assign busy           = (state_q != StIdle);

   systolic_skew_mux_2x2 #(
      .DATA_W (DATA_W)
   ) u_skew_mux (
      .state     (state_q),
      .cnt       (cnt_q),
      .a_q       (a_q),
      .b_q       (b_q),
      .feed_00_W (feed_00_W),
      .feed_10_W (feed_10_W),
      .feed_00_N (feed_00_N),
      .feed_01_N (feed_01_N)
   );

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Directed bench for systolic_feeder_2x2 driving a behavioural 2x2
// output-stationary array built from the feeder's edge outputs.
module tb_systolic_feeder_2x2;
   import systolic_feeder_2x2_pkg::*;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          pe_clear;
   logic          busy;
   logic [DW-1:0] f00w, f10w, f00n, f01n;
   logic [AW-1:0] acc00, acc01, acc10, acc11;

   int n_vec = 0;
   int n_err = 0;

   systolic_feeder_2x2_if #(.DATA_W(DW), .ACC_W(AW)) bus_if ();

   systolic_feeder_2x2 #(
      .DATA_W       (DW),
      .ACC_W        (AW),
      .DRAIN_CYCLES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus_if.slave),
      .pe_clear  (pe_clear),
      .feed_00_W (f00w),
      .feed_10_W (f10w),
      .feed_00_N (f00n),
      .feed_01_N (f01n),
      .acc_00    (acc00),
      .acc_01    (acc01),
      .acc_10    (acc10),
      .acc_11    (acc11),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Behavioural array: A flows east, B flows south, each PE accumulates a*b.
   logic [DW-1:0] a00_q, a10_q, b00_q, b01_q;
   always_ff @(posedge clk) begin
      if (pe_clear) begin
         a00_q <= '0; a10_q <= '0; b00_q <= '0; b01_q <= '0;
         acc00 <= '0; acc01 <= '0; acc10 <= '0; acc11 <= '0;
      end else begin
         a00_q <= f00w;
         a10_q <= f10w;
         b00_q <= f00n;
         b01_q <= f01n;
         acc00 <= acc00 + AW'(f00w) * AW'(f00n);
         acc01 <= acc01 + AW'(a00_q) * AW'(f01n);
         acc10 <= acc10 + AW'(f10w) * AW'(b00_q);
         acc11 <= acc11 + AW'(a10_q) * AW'(b01_q);
      end
   end

   function automatic logic [4*DW-1:0] pk16(input logic [DW-1:0] e00, e01, e10, e11);
      logic [4*DW-1:0] r;
      r = '0;
      r[IDX_00*DW +: DW] = e00;
      r[IDX_01*DW +: DW] = e01;
      r[IDX_10*DW +: DW] = e10;
      r[IDX_11*DW +: DW] = e11;
      return r;
   endfunction

   function automatic logic [4*AW-1:0] pk32(input logic [AW-1:0] e00, e01, e10, e11);
      logic [4*AW-1:0] r;
      r = '0;
      r[IDX_00*AW +: AW] = e00;
      r[IDX_01*AW +: AW] = e01;
      r[IDX_10*AW +: AW] = e10;
      r[IDX_11*AW +: AW] = e11;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a load and return one cycle after the handshake (CLEAR cycle).
   task automatic start_job(input logic [4*DW-1:0] a, input logic [4*DW-1:0] b);
      int n;
      bus_if.load_valid = 1'b1;
      bus_if.a_mat      = a;
      bus_if.b_mat      = b;
      #1;
      n = 0;
      while (!bus_if.load_ready && n < 20) begin
         tick();
         n++;
      end
      if (!bus_if.load_ready) begin
         n_vec++; n_err++;
         $display("FAIL load_ready_timeout: got 0 want 1");
      end
      tick();
      bus_if.load_valid = 1'b0;
   endtask

   task automatic wait_valid(output int cycles);
      cycles = 0;
      while (!bus_if.res_valid && cycles < 30) begin
         tick();
         cycles++;
      end
      if (!bus_if.res_valid) begin
         n_vec++; n_err++;
         $display("FAIL res_valid_timeout: got 0 want 1");
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      n_vec++;
      if (pe_clear !== 1'b1) begin
         n_err++; $display("FAIL reset_pe_clear: got %b want 1", pe_clear);
      end
      tick();
      reset = 1'b0;
      #1;
      n_vec++;
      if ({bus_if.load_ready, bus_if.res_valid, busy, pe_clear} !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 1000",
                  {bus_if.load_ready, bus_if.res_valid, busy, pe_clear});
      end
      n_vec++;
      if ({f00w, f00n, f10w, f01n} !== 64'd0 || bus_if.res_c !== 128'd0) begin
         n_err++;
         $display("FAIL reset_data: got feeds %h res %h want 0",
                  {f00w, f00n, f10w, f01n}, bus_if.res_c);
      end
   endtask

   task automatic test_latency_result();
      int c;
      start_job(pk16(1, 2, 3, 4), pk16(5, 6, 7, 8));
      wait_valid(c);
      n_vec++;
      if (1 + c != 7) begin
         n_err++; $display("FAIL latency: got %0d want 7", 1 + c);
      end
      n_vec++;
      if (bus_if.res_c !== pk32(19, 22, 43, 50)) begin
         n_err++; $display("FAIL basic_result: got %h want %h", bus_if.res_c, pk32(19, 22, 43, 50));
      end
      tick();
      n_vec++;
      if ({bus_if.res_valid, bus_if.load_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL basic_release: got %b want 01", {bus_if.res_valid, bus_if.load_ready});
      end
   endtask

   task automatic test_feed_schedule();
      logic [4*DW:0] exp_v, got_v;
      start_job(pk16(1, 2, 3, 4), pk16(5, 6, 7, 8));
      for (int k = 1; k <= 8; k++) begin
         case (k)
            1:       exp_v = {16'd0, 16'd0, 16'd0, 16'd0, 1'b1};
            2:       exp_v = {16'd1, 16'd5, 16'd0, 16'd0, 1'b0};
            3:       exp_v = {16'd2, 16'd7, 16'd3, 16'd6, 1'b0};
            4:       exp_v = {16'd0, 16'd0, 16'd4, 16'd8, 1'b0};
            default: exp_v = '0;
         endcase
         got_v = {f00w, f00n, f10w, f01n, pe_clear};
         n_vec++;
         if (got_v !== exp_v) begin
            n_err++; $display("FAIL feed_cycle%0d: got %h want %h", k, got_v, exp_v);
         end
         tick();
      end
   endtask

   task automatic test_hold_backpressure();
      int c;
      bus_if.res_ready = 1'b0;
      start_job(pk16(1, 2, 3, 4), pk16(5, 6, 7, 8));
      wait_valid(c);
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            bus_if.load_valid = 1'b1;
            bus_if.a_mat      = pk16(9, 9, 9, 9);
            bus_if.b_mat      = pk16(9, 9, 9, 9);
            #1;
         end
         n_vec++;
         if ({bus_if.res_valid, bus_if.load_ready, busy} !== 3'b101 ||
             bus_if.res_c !== pk32(19, 22, 43, 50)) begin
            n_err++;
            $display("FAIL hold_cycle%0d: got v/lr/busy %b res %h want 101 %h", k,
                     {bus_if.res_valid, bus_if.load_ready, busy}, bus_if.res_c,
                     pk32(19, 22, 43, 50));
         end
         tick();
      end
      bus_if.load_valid = 1'b0;
      bus_if.res_ready  = 1'b1;
      tick();
      n_vec++;
      if ({bus_if.res_valid, bus_if.load_ready, busy} !== 3'b010) begin
         n_err++;
         $display("FAIL hold_release: got %b want 010",
                  {bus_if.res_valid, bus_if.load_ready, busy});
      end
      tick();
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL hold_ignored_load: got busy %b want 0", busy);
      end
   endtask

   task automatic test_reset_mid_feed();
      int  c;
      logic seen;
      start_job(pk16(1, 2, 3, 4), pk16(5, 6, 7, 8));
      tick();
      tick();
      reset = 1'b1;
      #1;
      n_vec++;
      if (pe_clear !== 1'b1) begin
         n_err++; $display("FAIL midreset_pe_clear: got %b want 1", pe_clear);
      end
      tick();
      reset = 1'b0;
      #1;
      n_vec++;
      if ({busy, bus_if.load_ready, pe_clear, f00w, f00n, f10w, f01n} !== {3'b010, 64'd0}) begin
         n_err++;
         $display("FAIL midreset_idle: got busy/lr/clr %b feeds %h want 010 0",
                  {busy, bus_if.load_ready, pe_clear}, {f00w, f00n, f10w, f01n});
      end
      seen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (bus_if.res_valid) seen = 1'b1;
         tick();
      end
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++; $display("FAIL midreset_no_result: got %b want 0", seen);
      end
      start_job(pk16(1, 0, 0, 1), pk16(9, 8, 7, 6));
      wait_valid(c);
      n_vec++;
      if (bus_if.res_c !== pk32(9, 8, 7, 6)) begin
         n_err++; $display("FAIL midreset_next_job: got %h want %h", bus_if.res_c, pk32(9, 8, 7, 6));
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int c;
      bus_if.res_ready  = 1'b1;
      bus_if.load_valid = 1'b1;
      bus_if.a_mat      = pk16(1, 2, 3, 4);
      bus_if.b_mat      = pk16(5, 6, 7, 8);
      #1;
      tick();
      bus_if.a_mat = pk16(2, 0, 0, 2);
      bus_if.b_mat = pk16(1, 1, 1, 1);
      wait_valid(c);
      n_vec++;
      if (bus_if.res_c !== pk32(19, 22, 43, 50)) begin
         n_err++; $display("FAIL b2b_job1: got %h want %h", bus_if.res_c, pk32(19, 22, 43, 50));
      end
      tick();
      wait_valid(c);
      bus_if.load_valid = 1'b0;
      n_vec++;
      if (1 + c != 8) begin
         n_err++; $display("FAIL b2b_period: got %0d want 8", 1 + c);
      end
      n_vec++;
      if (bus_if.res_c !== pk32(2, 2, 2, 2)) begin
         n_err++; $display("FAIL b2b_job2: got %h want %h", bus_if.res_c, pk32(2, 2, 2, 2));
      end
      tick();
      tick();
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++; $display("FAIL b2b_idle: got busy %b want 0", busy);
      end
   endtask

   task automatic test_all_ones();
      int c;
      start_job({4{16'hFFFF}}, {4{16'hFFFF}});
      wait_valid(c);
      // 2 * (0xFFFF * 0xFFFF) = 0x1_FFFC_0002, truncated to 32 bits.
      n_vec++;
      if (bus_if.res_c !== {4{32'hFFFC_0002}}) begin
         n_err++; $display("FAIL all_ones: got %h want %h", bus_if.res_c, {4{32'hFFFC_0002}});
      end
      tick();
   endtask

   initial begin
      reset             = 1'b1;
      bus_if.load_valid = 1'b0;
      bus_if.a_mat      = '0;
      bus_if.b_mat      = '0;
      bus_if.res_ready  = 1'b1;
      test_reset();
      test_latency_result();
      test_feed_schedule();
      test_hold_backpressure();
      test_reset_mid_feed();
      test_back_to_back();
      test_all_ones();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
